// File: rtl/turbo_result_pingpong_buf.sv
// rtl/turbo_result_pingpong_buf.sv - multi-bank ping-pong result buffer with explicit per-bank ownership
// Decoder fills the bank at wb while the consumer drains the bank at rb.
module turbo_result_pingpong_buf #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 13,
  parameter int NUM_BANKS = 2,
  parameter int BANK_W    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_start,
  output logic              wr_ready,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_bitrev,
  input  logic              wr_last,
  input  logic              wr_abort,
  output logic              rd_avail,
  input  logic              rd_start,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic [ADDR_W:0]   rd_len,
  input  logic              rd_done,
  output logic              err_ovf,
  output logic              err_unf
);

  typedef enum logic [1:0] {FREE, FILLING, FULL, DRAINING} bank_state_e;

  localparam int DEPTH = NUM_BANKS << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  bank_state_e       state_q [NUM_BANKS];
  bank_state_e       state_d [NUM_BANKS];
  logic [ADDR_W:0]   len_q   [NUM_BANKS];
  logic [ADDR_W:0]   len_d   [NUM_BANKS];
  logic [BANK_W-1:0] wb_q, wb_d, rb_q, rb_d;
  logic              wr_ready_q, wr_ready_d;
  logic              rd_avail_q, rd_avail_d;
  logic              rd_valid_q, rd_valid_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic [ADDR_W:0]   rd_len_q, rd_len_d;
  logic              err_ovf_q, err_ovf_d;
  logic              err_unf_q, err_unf_d;
  logic              mem_we;
  logic              filling, draining;
  logic [DATA_W-1:0] wr_word;

  always_comb begin
    for (int i = 0; i < DATA_W; i++) begin
      wr_word[i] = wr_bitrev ? wr_data[DATA_W-1-i] : wr_data[i];
    end
  end

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    wb_d       = wb_q;
    rb_d       = rb_q;
    rd_data_d  = rd_data_q;
    rd_len_d   = rd_len_q;
    err_ovf_d  = err_ovf_q;
    err_unf_d  = err_unf_q;
    rd_valid_d = 1'b0;
    mem_we     = 1'b0;
    filling    = (state_q[wb_q] == FILLING);
    draining   = (state_q[rb_q] == DRAINING);

    // Write side only ever touches bank wb, which is FREE or FILLING here.
    if (wr_start && wr_ready_q) begin
      state_d[wb_q] = FILLING;
    end
    if (filling && wr_abort) begin
      state_d[wb_q] = FREE;
    end else if (wr_en) begin
      if (filling) begin
        mem_we = 1'b1;
        if (wr_last) begin
          len_d[wb_q]   = (ADDR_W+1)'(wr_addr) + 1'b1;
          state_d[wb_q] = FULL;
          wb_d          = wb_q + 1'b1;
        end
      end else begin
        err_ovf_d = 1'b1;
      end
    end

    // Read side only ever touches bank rb, which is FULL or DRAINING here.
    if (rd_start) begin
      if (rd_avail_q) begin
        state_d[rb_q] = DRAINING;
        rd_len_d      = len_q[rb_q];
      end else begin
        err_unf_d = 1'b1;
      end
    end
    if (rd_en) begin
      if (draining) begin
        rd_valid_d = 1'b1;
        rd_data_d  = mem[{rb_q, rd_addr}];
      end else begin
        err_unf_d = 1'b1;
      end
    end
    if (rd_done && draining) begin
      state_d[rb_q] = FREE;
      rb_d          = rb_q + 1'b1;
    end

    wr_ready_d = (state_d[wb_d] == FREE);
    rd_avail_d = (state_d[rb_d] == FULL);
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[{wb_q, wr_addr}] <= wr_word;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_BANKS; i++) begin
        state_q[i] <= FREE;
        len_q[i]   <= '0;
      end
      wb_q       <= '0;
      rb_q       <= '0;
      wr_ready_q <= 1'b1;
      rd_avail_q <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      rd_len_q   <= '0;
      err_ovf_q  <= 1'b0;
      err_unf_q  <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_BANKS; i++) begin
        state_q[i] <= state_d[i];
        len_q[i]   <= len_d[i];
      end
      wb_q       <= wb_d;
      rb_q       <= rb_d;
      wr_ready_q <= wr_ready_d;
      rd_avail_q <= rd_avail_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      rd_len_q   <= rd_len_d;
      err_ovf_q  <= err_ovf_d;
      err_unf_q  <= err_unf_d;
    end
  end

  assign wr_ready = wr_ready_q;
  assign rd_avail = rd_avail_q;
  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;
  assign rd_len   = rd_len_q;
  assign err_ovf  = err_ovf_q;
  assign err_unf  = err_unf_q;

endmodule

// File: tb/tb_turbo_result_pingpong_buf.sv
// tb/tb_turbo_result_pingpong_buf.sv - directed vector bench for turbo_result_pingpong_buf
module tb_turbo_result_pingpong_buf;

  localparam int DATA_W    = 8;
  localparam int ADDR_W    = 13;
  localparam int NUM_BANKS = 2;
  localparam int BANK_W    = 1;

  logic              clk = 1'b0;
  logic              rst;
  logic              wr_start, wr_ready, wr_en, wr_bitrev, wr_last, wr_abort;
  logic [ADDR_W-1:0] wr_addr, rd_addr;
  logic [DATA_W-1:0] wr_data, rd_data;
  logic              rd_avail, rd_start, rd_en, rd_valid, rd_done;
  logic [ADDR_W:0]   rd_len;
  logic              err_ovf, err_unf;

  turbo_result_pingpong_buf #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_BANKS(NUM_BANKS), .BANK_W(BANK_W)
  ) dut (
    .clk(clk), .rst(rst),
    .wr_start(wr_start), .wr_ready(wr_ready), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_bitrev(wr_bitrev), .wr_last(wr_last), .wr_abort(wr_abort),
    .rd_avail(rd_avail), .rd_start(rd_start), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_len(rd_len), .rd_done(rd_done),
    .err_ovf(err_ovf), .err_unf(err_unf)
  );

  always #5 clk = ~clk;

  // expected = {wr_ready, rd_avail, rd_valid, rd_data, rd_len, err_ovf, err_unf}
  typedef struct {
    logic              ws, we, wbr, wl, wab, rs, re, rdn;
    logic [ADDR_W-1:0] wa, ra;
    logic [DATA_W-1:0] wd;
    logic [26:0]       exp;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic logic [26:0] pk(int rdy, int av, int vld, int dat, int len, int ovf, int unf);
    return {rdy != 0, av != 0, vld != 0, 8'(dat), 14'(len), ovf != 0, unf != 0};
  endfunction

  task automatic add(int ws, int we, int wa, int wd, int wbr, int wl, int wab,
                     int rs, int re, int ra, int rdn, logic [26:0] exp);
    vec_t v;
    v.ws = (ws != 0); v.we = (we != 0); v.wa = 13'(wa); v.wd = 8'(wd);
    v.wbr = (wbr != 0); v.wl = (wl != 0); v.wab = (wab != 0);
    v.rs = (rs != 0); v.re = (re != 0); v.ra = 13'(ra); v.rdn = (rdn != 0);
    v.exp = exp;
    vecs.push_back(v);
  endtask

  task automatic drive(vec_t v);
    wr_start = v.ws; wr_en = v.we; wr_addr = v.wa; wr_data = v.wd; wr_bitrev = v.wbr;
    wr_last = v.wl; wr_abort = v.wab; rd_start = v.rs; rd_en = v.re; rd_addr = v.ra;
    rd_done = v.rdn;
  endtask

  task automatic check(string name, logic [26:0] exp);
    logic [26:0] act;
    act = {wr_ready, rd_avail, rd_valid, rd_data, rd_len, err_ovf, err_unf};
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Single frame of 16 words, then drain it.
    add(1,0,0,0,0,0,0, 0,0,0,0, pk(0,0,0,0,0,0,0));
    for (int i = 0; i < 16; i++)
      add(0,1,i,i,0,(i == 15),0, 0,0,0,0, pk((i == 15),(i == 15),0,0,0,0,0));
    add(0,0,0,0,0,0,0, 1,0,0,0, pk(1,0,0,0,16,0,0));
    for (int i = 0; i < 16; i++)
      add(0,0,0,0,0,0,0, 0,1,i,0, pk(1,0,1,i,16,0,0));
    add(0,0,0,0,0,0,0, 0,0,0,0, pk(1,0,0,15,16,0,0));
    add(0,0,0,0,0,0,0, 0,0,0,1, pk(1,0,0,15,16,0,0));
    // Both banks full, third claim ignored, stray write flagged.
    add(1,0,0,0,0,0,0, 0,0,0,0, pk(0,0,0,15,16,0,0));
    add(0,1,0,8'hA0,0,0,0, 0,0,0,0, pk(0,0,0,15,16,0,0));
    add(0,1,1,8'hA1,0,1,0, 0,0,0,0, pk(1,1,0,15,16,0,0));
    add(1,0,0,0,0,0,0, 0,0,0,0, pk(0,1,0,15,16,0,0));
    add(0,1,0,8'hB0,0,1,0, 0,0,0,0, pk(0,1,0,15,16,0,0));
    add(1,0,0,0,0,0,0, 0,0,0,0, pk(0,1,0,15,16,0,0));
    add(0,1,0,8'hFF,0,0,0, 0,0,0,0, pk(0,1,0,15,16,1,0));
    add(0,0,0,0,0,0,0, 1,0,0,0, pk(0,0,0,15,2,1,0));
    add(0,0,0,0,0,0,0, 0,1,0,0, pk(0,0,1,8'hA0,2,1,0));
    add(0,0,0,0,0,0,0, 0,1,1,0, pk(0,0,1,8'hA1,2,1,0));
    add(0,0,0,0,0,0,0, 0,0,0,1, pk(1,1,0,8'hA1,2,1,0));
    add(0,0,0,0,0,0,0, 1,0,0,0, pk(1,0,0,8'hA1,1,1,0));
    add(0,0,0,0,0,0,0, 0,1,0,1, pk(1,0,1,8'hB0,1,1,0));
    // Bit reversal versus plain store.
    add(1,0,0,0,0,0,0, 0,0,0,0, pk(0,0,0,8'hB0,1,1,0));
    add(0,1,5,8'h03,1,0,0, 0,0,0,0, pk(0,0,0,8'hB0,1,1,0));
    add(0,1,6,8'h03,0,1,0, 0,0,0,0, pk(1,1,0,8'hB0,1,1,0));
    add(0,0,0,0,0,0,0, 1,0,0,0, pk(1,0,0,8'hB0,7,1,0));
    add(0,0,0,0,0,0,0, 0,1,5,0, pk(1,0,1,8'hC0,7,1,0));
    add(0,0,0,0,0,0,0, 0,1,6,0, pk(1,0,1,8'h03,7,1,0));
    add(0,0,0,0,0,0,0, 0,0,0,1, pk(1,0,0,8'h03,7,1,0));
    // Abort at addr 7 coincident with wr_last: word dropped, bank reused.
    add(1,0,0,0,0,0,0, 0,0,0,0, pk(0,0,0,8'h03,7,1,0));
    for (int i = 0; i < 7; i++)
      add(0,1,i,8'hE0 + i,0,0,0, 0,0,0,0, pk(0,0,0,8'h03,7,1,0));
    add(0,1,7,8'hEE,0,1,1, 0,0,0,0, pk(1,0,0,8'h03,7,1,0));
    add(1,0,0,0,0,0,0, 0,0,0,0, pk(0,0,0,8'h03,7,1,0));
    add(0,1,0,8'h55,0,1,0, 0,0,0,0, pk(1,1,0,8'h03,7,1,0));
    add(0,0,0,0,0,0,0, 1,0,0,0, pk(1,0,0,8'h03,1,1,0));
    add(0,0,0,0,0,0,0, 0,1,7,0, pk(1,0,1,8'h07,1,1,0));
    add(0,0,0,0,0,0,0, 0,1,0,0, pk(1,0,1,8'h55,1,1,0));
    add(0,0,0,0,0,0,0, 0,0,0,1, pk(1,0,0,8'h55,1,1,0));
    // Underflow: rd_start without avail, rd_en without draining bank.
    add(0,0,0,0,0,0,0, 1,0,0,0, pk(1,0,0,8'h55,1,1,1));
    add(0,0,0,0,0,0,0, 0,1,0,0, pk(1,0,0,8'h55,1,1,1));
    // Last word at top address gives len = 2^ADDR_W.
    add(1,0,0,0,0,0,0, 0,0,0,0, pk(0,0,0,8'h55,1,1,1));
    add(0,1,8191,8'h5A,0,1,0, 0,0,0,0, pk(1,1,0,8'h55,1,1,1));
    add(0,0,0,0,0,0,0, 1,0,0,0, pk(1,0,0,8'h55,8192,1,1));
    add(0,0,0,0,0,0,0, 0,1,8191,0, pk(1,0,1,8'h5A,8192,1,1));
    add(0,0,0,0,0,0,0, 0,0,0,1, pk(1,0,0,8'h5A,8192,1,1));
    // Concurrent write and read activity on different banks.
    add(1,0,0,0,0,0,0, 0,0,0,0, pk(0,0,0,8'h5A,8192,1,1));
    add(0,1,0,8'h11,0,1,0, 0,0,0,0, pk(1,1,0,8'h5A,8192,1,1));
    add(1,0,0,0,0,0,0, 1,0,0,0, pk(0,0,0,8'h5A,1,1,1));
    add(0,1,0,8'h22,0,1,0, 0,1,0,0, pk(0,0,1,8'h11,1,1,1));
    add(0,0,0,0,0,0,0, 0,0,0,1, pk(1,1,0,8'h11,1,1,1));
    add(0,0,0,0,0,0,0, 1,0,0,0, pk(1,0,0,8'h11,1,1,1));
    add(0,0,0,0,0,0,0, 0,1,0,0, pk(1,0,1,8'h22,1,1,1));

    rst = 1'b1;
    wr_start = 0; wr_en = 0; wr_addr = '0; wr_data = '0; wr_bitrev = 0; wr_last = 0;
    wr_abort = 0; rd_start = 0; rd_en = 0; rd_addr = '0; rd_done = 0;
    tick();
    tick();
    check("reset", pk(1,0,0,0,0,0,0));
    rst = 1'b0;

    foreach (vecs[i]) begin
      drive(vecs[i]);
      tick();
      check($sformatf("vec%0d", i), vecs[i].exp);
    end

    // Reset in the middle of a read burst.
    wr_start = 0; wr_en = 0; wr_last = 0; rd_start = 0; rd_done = 0;
    rd_en = 1; rd_addr = '0;
    tick();
    check("burst", pk(1,0,1,8'h22,1,1,1));
    rst = 1'b1;
    tick();
    check("rst_mid", pk(1,0,0,0,0,0,0));
    rst = 1'b0; rd_en = 0; rd_start = 1;
    tick();
    check("post_rst_unf", pk(1,0,0,0,0,0,1));
    rd_start = 0; wr_start = 1;
    tick();
    check("post_rst_claim", pk(0,0,0,0,0,0,1));
    wr_start = 0; wr_en = 1; wr_addr = '0; wr_data = 8'h09; wr_last = 1;
    tick();
    check("post_rst_frame", pk(1,1,0,0,0,0,1));
    wr_en = 0; wr_last = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/turbo_result_pingpong_buf.md
Name: turbo_result_pingpong_buf

Overview:
Multi-bank result buffer for the turbo decoder's hard-decision output. The decoder side fills one bank at frame rate while the downstream consumer drains a previously completed bank. Bank ownership is explicit: a state machine per bank plus a full/avail handshake, which replaces the fixed decMode-bit addressing. Data width, frame depth and bank count are parametrised, with an optional per-word bit-reversal on the write path.

Parameters:
DATA_W, 8, width of one stored result word
ADDR_W, 13, word address width per bank (max frame 2^ADDR_W words)
NUM_BANKS, 2, bank count; legal values 2 and 4
BANK_W, 1, log2(NUM_BANKS); must be consistent with NUM_BANKS

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous active-high reset
wr_start  in  1  pulse: claim next bank for writing
wr_ready  out  1  a FREE bank is available at the write pointer
wr_en  in  1  write strobe
wr_addr  in  ADDR_W  word address within current write bank
wr_data  in  DATA_W  result word
wr_bitrev  in  1  1: store wr_data bit-reversed (bit i -> DATA_W-1-i)
wr_last  in  1  qualifies wr_en: final word of frame
wr_abort  in  1  pulse: discard bank being filled
rd_avail  out  1  a FULL bank is waiting at the read pointer
rd_start  in  1  pulse: claim FULL bank for draining
rd_en  in  1  read strobe
rd_addr  in  ADDR_W  word address within current read bank
rd_data  out  DATA_W  registered read data
rd_valid  out  1  rd_data valid (rd_en delayed one cycle)
rd_len  out  ADDR_W+1  word count of the bank being drained
rd_done  in  1  pulse: release drained bank
err_ovf  out  1  sticky: write dropped (no FILLING bank)
err_unf  out  1  sticky: rd_start without rd_avail, or rd_en with no DRAINING bank

Behaviour:
- Storage: one dual-port RAM of NUM_BANKS*2^ADDR_W words. Physical write address is {wb, wr_addr}; physical read address is {rb, rd_addr}. wb and rb are BANK_W-bit round-robin pointers that wrap modulo NUM_BANKS.
- Per-bank state: FREE, FILLING, FULL, DRAINING. Each bank holds a len register of ADDR_W+1 bits.
- Reset: all banks FREE; wb=rb=0; wr_ready=1; rd_avail=0; rd_valid=0; rd_data=0; rd_len=0; err_ovf=err_unf=0. Reset mid-frame discards all contents and state.
- wr_ready = state[wb]==FREE, registered, so it reflects state after the previous edge.
- rd_avail = state[rb]==FULL, also registered.
- wr_start with wr_ready=1: bank[wb] FREE->FILLING. wr_start with wr_ready=0 is ignored, with no error.
- wr_en while bank[wb] is FILLING: RAM written at that edge.
  - Data stored is bit-reversed when wr_bitrev=1.
- wr_en with wr_last: the word is written, len[wb] = wr_addr+1, bank goes FILLING->FULL, and wb increments.
- wr_en while no bank is FILLING: write suppressed and err_ovf set.
- wr_abort while FILLING: bank returns to FREE and wb is unchanged. Abort in the same cycle as wr_last: abort wins and the word is not written.
- rd_start with rd_avail=1: bank[rb] FULL->DRAINING, and rd_len takes len[rb] on the same edge. rd_start with rd_avail=0 is ignored and sets err_unf.
- rd_en while bank[rb] is DRAINING: rd_data holds RAM[{rb,rd_addr}] one cycle later, with rd_valid=1 that cycle. rd_data holds its value when rd_valid=0.
- rd_en with no DRAINING bank: rd_valid stays 0 and err_unf is set.
- rd_done while DRAINING: bank goes to FREE and rb increments. A rd_en issued in the same cycle as rd_done still returns data next cycle, because the address is latched before release.
- Simultaneous events: write-side and read-side transitions on different banks in the same cycle both take effect. A bank released by rd_done is seen by wr_ready on the following cycle.
- Read/write collision on the same physical address is impossible by construction, since a bank is never both FILLING and DRAINING.
- len for a frame where wr_last arrives at wr_addr=2^ADDR_W-1 is 2^ADDR_W, which is why len is ADDR_W+1 bits.
- err flags clear only on rst.

Test Plan:
- Reset: assert rst 2 cycles -> wr_ready=1, rd_avail=0, rd_valid=0, rd_len=0, err_ovf=err_unf=0.
- Single frame: wr_start, write addr 0..15 with data=addr, wr_last at 15 -> rd_avail=1 one cycle later. Then rd_start -> rd_len=16; read 0..15 -> rd_data=0..15, each 1 cycle after rd_en.
- Ping-pong full (NUM_BANKS=2): fill two frames without reading -> wr_ready=0. A third wr_start is ignored; wr_en then sets err_ovf=1 and RAM is unchanged. rd_start/rd_done on bank0 -> wr_ready=1 the next cycle.
- Bit reversal: wr_bitrev=1, wr_data=8'b0000_0011 at addr 5 -> read of addr 5 returns 8'b1100_0000. With wr_bitrev=0 the value returns unchanged.
- Abort and underflow: wr_abort mid-frame at addr 7 -> rd_avail stays 0 and the next wr_start reuses the same bank. rd_start with rd_avail=0 -> err_unf=1.
- Reset mid-operation: rst asserted during a DRAINING read burst -> next cycle rd_valid=0, all banks FREE, wr_ready=1, rd_avail=0.
